// File: rtl/double_framebuffer.sv
// double_framebuffer: two-bank pixel store with vblank-synchronised swap and back-bank clear.
// Define FRAMEBUFFER_CLEAR_EN to build the clear engine; otherwise clear inputs are ignored.
module double_framebuffer #(
    parameter int BITS_PER_PIXEL = 4,
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_N,
    input  logic [31:0]               i_Read_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Read_Data,
    input  logic                      i_Write_Enable,
    input  logic [31:0]               i_Write_Addr,
    input  logic [BITS_PER_PIXEL-1:0] i_Write_Data,
    output logic                      o_Write_Ready,
    input  logic                      i_Swap_Request,
    input  logic                      i_Vblank,
    output logic                      o_Swap_Pending,
    output logic                      o_Front_Buffer,
    input  logic                      i_Clear_Start,
    input  logic [BITS_PER_PIXEL-1:0] i_Clear_Color,
    output logic                      o_Clear_Busy
);
    localparam int DEPTH = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int AW    = $clog2(2 * DEPTH);

    logic [BITS_PER_PIXEL-1:0] mem [2*DEPTH];
    logic [BITS_PER_PIXEL-1:0] rd_q, rd_d, clr_color, mem_wdata;
    logic [AW-1:0]             clr_addr, mem_waddr;
    logic                      front_q, front_d, pending_q, pending_d, vb_q, vb_d;
    logic                      busy, swap, mem_we;

`ifdef FRAMEBUFFER_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                    state_q, state_d;
    logic [AW-1:0]             cnt_q, cnt_d;
    logic [BITS_PER_PIXEL-1:0] color_q, color_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        if (state_q == IDLE) begin
            if (i_Clear_Start) begin
                state_d = CLEAR;
                cnt_d   = '0;
                color_d = i_Clear_Color;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign clr_addr  = cnt_q;
    assign clr_color = color_q;
`else
    logic unused_clear;
    assign unused_clear = ^{i_Clear_Start, i_Clear_Color};
    assign busy         = 1'b0;
    assign clr_addr     = '0;
    assign clr_color    = '0;
`endif

    always_comb begin
        vb_d      = i_Vblank;
        swap      = pending_q && i_Vblank && !vb_q && !busy;
        front_d   = front_q ^ swap;
        pending_d = swap ? 1'b0 : (pending_q || i_Swap_Request);
        rd_d      = (i_Read_Addr < 32'(DEPTH))
                    ? mem[(front_q ? AW'(DEPTH) : AW'(0)) + AW'(i_Read_Addr)] : '0;
        // Writes always target the back bank; clear owns the port while busy.
        mem_we    = busy || (i_Write_Enable && i_Write_Addr < 32'(DEPTH));
        mem_waddr = (front_q ? AW'(0) : AW'(DEPTH)) + (busy ? clr_addr : AW'(i_Write_Addr));
        mem_wdata = busy ? clr_color : i_Write_Data;
    end

    always_ff @(posedge i_Clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            rd_q      <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            vb_q      <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            vb_q      <= vb_d;
        end
    end

    assign o_Read_Data    = rd_q;
    assign o_Front_Buffer = front_q;
    assign o_Swap_Pending = pending_q;
    assign o_Clear_Busy   = busy;
    assign o_Write_Ready  = !busy;
endmodule

// File: tb/tb_double_framebuffer.sv
// tb_double_framebuffer: directed checks of write/read, swap timing and (when built) the clear engine.
module tb_double_framebuffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ra, wa;
    logic [3:0]  rdata, wd, cc;
    logic        we, ready, req, vb, pend, front, cs, busy;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    double_framebuffer #(.BITS_PER_PIXEL(4), .FRAME_WIDTH(4), .FRAME_HEIGHT(2)) dut (
        .i_Clock(clk), .i_Reset_N(rst_n),
        .i_Read_Addr(ra), .o_Read_Data(rdata),
        .i_Write_Enable(we), .i_Write_Addr(wa), .i_Write_Data(wd), .o_Write_Ready(ready),
        .i_Swap_Request(req), .i_Vblank(vb), .o_Swap_Pending(pend), .o_Front_Buffer(front),
        .i_Clear_Start(cs), .i_Clear_Color(cc), .o_Clear_Busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [3:0] e);
        ra = a;
        tick();
        check(tag, rdata, e);
    endtask

    task automatic swap_now(input logic exp_front);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("swap_pend_set", pend, 1);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("swap_front", front, exp_front);
        check("swap_pend_clr", pend, 0);
        tick();
    endtask

    initial begin
        int n;
        ra = 0; wa = 0; wd = 0; cc = 0; we = 0; req = 0; vb = 0; cs = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdata", rdata, 0);
        check("rst_front", front, 0);
        check("rst_pend", pend, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
        tick(); tick();
        rst_n = 1'b1;

        wr(3, 4'hA);
        wr(0, 4'h3);
        swap_now(1'b1);
        rd_chk("rd3_bank1", 3, 4'hA);
        wr(3, 4'h6);
        wr(8, 4'hF);
        rd_chk("rd8_oor", 8, 4'h0);
        rd_chk("rd0_keep", 0, 4'h3);
        rd_chk("rd3_front_keep", 3, 4'hA);

        req = 1'b1; vb = 1'b1;
        tick();
        req = 1'b0;
        check("coin_pend", pend, 1);
        check("coin_noswap", front, 1);
        vb = 1'b0;
        tick();
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("coin_swap", front, 0);
        check("coin_pend_clr", pend, 0);
        tick();
        rd_chk("rd3_bank0", 3, 4'h6);

`ifdef FRAMEBUFFER_CLEAR_EN
        cs = 1'b1; cc = 4'h5; ra = 3;
        tick();
        cs = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            check("ready_inv", ready, !busy);
            if (i == 3) check("rd_during_clear", rdata, 4'h6);
            we = (i == 1); wa = 2; wd = 4'hE;
            tick();
        end
        we = 1'b0;
        check("busy_cycles", n, 8);
        swap_now(1'b1);
        for (int a = 0; a < 8; a++) rd_chk("clr_all", a, 4'h5);

        req = 1'b1;
        tick();
        req = 1'b0; cs = 1'b1;
        tick();
        cs = 1'b0;
        check("defer_busy", busy, 1);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("defer_front", front, 1);
        check("defer_pend", pend, 1);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("defer_clear_done", busy, 0);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("defer_swap", front, 0);
        check("defer_pend_clr", pend, 0);
        tick();

        for (int a = 0; a < 8; a++) wr(a, 4'(a + 8));
        ra = 3;
        cs = 1'b1; cc = 4'h5;
        tick();
        cs = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        check("abort_front", front, 0);
        check("abort_pend", pend, 0);
        check("abort_rdata", rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_idle", busy, 0);
        swap_now(1'b1);
        for (int a = 0; a < 8; a++) rd_chk("abort_mem", a, a < 4 ? 4'h5 : 4'(a + 8));
`else
        cs = 1'b1; cc = 4'h5;
        tick();
        check("noclr_busy", busy, 0);
        check("noclr_ready", ready, 1);
        cs = 1'b0;
        tick();
        check("noclr_busy2", busy, 0);
        wr(5, 4'h9);
        swap_now(1'b1);
        rd_chk("noclr_rd3", 3, 4'hA);
        rd_chk("noclr_rd0", 0, 4'h3);
        rd_chk("noclr_rd5", 5, 4'h9);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/double_framebuffer.md
DOUBLE_FRAMEBUFFER -- requirements
Module: double_framebuffer

Interface
REQ-001 SHALL have parameter BITS_PER_PIXEL, default 4, the pixel width in bits.
REQ-002 SHALL have parameter FRAME_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 480, lines per frame; DEPTH = FRAME_WIDTH*FRAME_HEIGHT pixels per bank.
REQ-004 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Reset_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_Read_Addr, input, 32 bits: display pixel index into the front bank.
REQ-007 SHALL have port o_Read_Data, output, BITS_PER_PIXEL: registered front-bank pixel.
REQ-008 SHALL have ports i_Write_Enable (input, 1), i_Write_Addr (input, 32) and i_Write_Data (input, BITS_PER_PIXEL): the back-bank write port.
REQ-009 SHALL have port o_Write_Ready, output, 1 bit: high when external writes are accepted.
REQ-010 SHALL have ports i_Swap_Request (input, 1), i_Vblank (input, 1), o_Swap_Pending (output, 1) and o_Front_Buffer (output, 1: index of the displayed bank).
REQ-011 SHALL have ports i_Clear_Start (input, 1), i_Clear_Color (input, BITS_PER_PIXEL) and o_Clear_Busy (output, 1).

Function
REQ-012 SHALL store two banks of DEPTH pixels in block RAM; the physical index is bank*DEPTH + addr.
REQ-013 SHALL register o_Read_Data one cycle after i_Read_Addr is presented, reading bank o_Front_Buffer as it stood in the sampling cycle.
REQ-014 SHALL return 0 on o_Read_Data for i_Read_Addr >= DEPTH.
REQ-015 SHALL write i_Write_Data to bank !o_Front_Buffer at i_Write_Addr when i_Write_Enable && o_Write_Ready && i_Write_Addr < DEPTH; all other writes are dropped silently.
REQ-016 SHALL never write the front bank.
REQ-017 SHALL set o_Swap_Pending in the cycle after i_Swap_Request is sampled high; a request while already pending has no further effect.
REQ-018 SHALL detect the rising edge of i_Vblank from a registered copy of i_Vblank.
REQ-019 SHALL toggle o_Front_Buffer and clear o_Swap_Pending in the same edge on a vblank rising edge while pending and the FSM is IDLE.
REQ-020 SHALL defer a swap while CLEAR is active until the next vblank rising edge that finds the FSM IDLE.
REQ-021 SHALL, when i_Swap_Request and a qualifying vblank edge coincide with pending=0, only set pending; no swap occurs in that cycle.
REQ-022 SHALL implement FSM states IDLE and CLEAR.
REQ-023 SHALL go from IDLE to CLEAR when i_Clear_Start is high, latching i_Clear_Color and zeroing a clear counter.
REQ-024 SHALL, in CLEAR, write the latched colour to back-bank address counter each cycle and increment the counter; after the write at DEPTH-1 it SHALL return to IDLE, DEPTH cycles in total.
REQ-025 SHALL ignore i_Clear_Start while in CLEAR.
REQ-026 SHALL clear the bank that was back at clear start; a swap cannot occur mid-clear.
REQ-027 SHALL drive o_Clear_Busy = (state == CLEAR) and o_Write_Ready = !o_Clear_Busy.
REQ-028 SHALL keep display reads fully serviced during CLEAR.

Reset
REQ-029 SHALL, while i_Reset_N is low, asynchronously force o_Read_Data=0, o_Front_Buffer=0, o_Swap_Pending=0, state=IDLE, counter=0 and the vblank history register=0.
REQ-030 SHALL abort an active clear on reset, leaving the partially cleared contents in place.
REQ-031 SHALL not initialise RAM contents on reset.

Configuration
REQ-032 SHALL build the clear engine, i_Clear_Start/i_Clear_Color behaviour and the CLEAR state only when macro FRAMEBUFFER_CLEAR_EN is defined.
REQ-033 SHALL, without FRAMEBUFFER_CLEAR_EN, keep all ports, ignore the clear inputs, tie o_Clear_Busy=0 and o_Write_Ready=1, and swap on any qualifying vblank edge.

Verification (BITS_PER_PIXEL=4, FRAME_WIDTH=4, FRAME_HEIGHT=2, DEPTH=8)
REQ-034 SHALL cover: write addr 3 = 0xA, swap request, vblank pulse, then read addr 3 -> o_Front_Buffer=1 and o_Read_Data=0xA one cycle after the address.
REQ-035 SHALL cover: write addr 8 = 0xF, then read addr 8 -> no RAM change, o_Read_Data=0.
REQ-036 SHALL cover: clear start with colour 0x5 -> o_Clear_Busy high for exactly 8 cycles, o_Write_Ready low over the same cycles, a write to addr 2 issued during the clear is dropped, and after a swap every address reads 0x5.
REQ-037 SHALL cover: swap request, then a vblank edge during a clear -> no toggle and pending stays 1; the next vblank edge after the clear completes -> toggle.
REQ-038 SHALL cover: reset asserted at clear cycle 4 -> outputs immediately 0 and state IDLE; addresses 0-3 read 0x5 and addresses 4-7 are unchanged.
REQ-039 SHALL cover: build without FRAMEBUFFER_CLEAR_EN and pulse i_Clear_Start -> o_Clear_Busy=0, o_Write_Ready=1 and no RAM change.
